// File: rtl/fifo_array_reader.sv
// fifo_array_reader
//
// Drain-side adapter for a multi-lane FIFO array whose lanes share one read
// enable and one OR'd empty flag. Read enables are issued against a small
// credit-based prefetch buffer. Each lane vector is captured one cycle after
// its read and presented on a valid/ready stream. in_rd_en never depends
// combinationally on out_ready.
//
// Parameters:
//   FIFO_DATA_WIDTH  width of each lane
//   ARRAY_SIZE       number of lanes
//   SKID_DEPTH       prefetch buffer entries (3 or more; 3 sustains 1 beat/cycle)
//   BEAT_CNT_WIDTH   width of the delivered-beat counter
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_dout    in   lane vector from the array, valid the cycle after a read
//   in_empty   in   OR of the lane empty flags
//   in_rd_en   out  read enable to all lanes
//   out_data   out  head vector (don't-care while out_valid is low)
//   out_valid  out  head vector present
//   out_ready  in   downstream accepts the head
//   occupancy  out  number of buffered vectors
//   beat_cnt   out  vectors delivered since reset, wraps

module fifo_array_reader #(
  parameter int unsigned FIFO_DATA_WIDTH = 32,
  parameter int unsigned ARRAY_SIZE      = 4,
  parameter int unsigned SKID_DEPTH      = 3,
  parameter int unsigned BEAT_CNT_WIDTH  = 16,
  localparam int unsigned OCC_WIDTH      = $clog2(SKID_DEPTH + 1),
  localparam int unsigned PTR_WIDTH      = $clog2(SKID_DEPTH)
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0]      in_dout,
  input  logic                                            in_empty,
  output logic                                            in_rd_en,
  output logic [ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0]      out_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [OCC_WIDTH-1:0]                            occupancy,
  output logic [BEAT_CNT_WIDTH-1:0]                       beat_cnt
);

  localparam int unsigned SUM_WIDTH = OCC_WIDTH + 1;

  typedef logic [ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0] vec_t;

  // Prefetch storage. Contents are never reset; occupancy qualifies them.
  vec_t                      mem_q [SKID_DEPTH];

  logic [PTR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_WIDTH-1:0]      occ_q, occ_d;
  logic                      inflight_q, inflight_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic                      capture;
  logic                      pop;
  logic                      rd_issue;
  logic [SUM_WIDTH-1:0]      committed;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    if (ptr == PTR_WIDTH'(SKID_DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  // Entries already stored plus the one whose data arrives next edge. A read
  // is only issued while this leaves room, so the buffer can never overflow
  // regardless of what out_ready does.
  assign committed = {1'b0, occ_q} + SUM_WIDTH'(inflight_q);
  assign rd_issue  = !in_empty && (committed < SUM_WIDTH'(SKID_DEPTH));

  // Reset gates the port directly so the read enable drops without a clock
  // edge; the inflight flop is held by its own asynchronous reset.
  assign in_rd_en  = reset && rd_issue;

  assign capture   = inflight_q;
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign beat_cnt  = beat_cnt_q;

  always_comb begin
    inflight_d = rd_issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    beat_cnt_d = beat_cnt_q;

    if (capture) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d   = ptr_inc(rd_ptr_q);
      beat_cnt_d = beat_cnt_q + 1'b1;
    end

    unique case ({capture, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= in_dout;
    end
  end

endmodule

// File: tb/tb_fifo_array_reader.sv
// Testbench for fifo_array_reader. A queue-based model of the FIFO array feeds
// the DUT; every vector the array hands out is pushed into a scoreboard, and
// an independent monitor pops and compares whenever a beat is delivered.

module tb_fifo_array_reader;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned D  = 3;
  localparam int unsigned BW = 4;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  vec_t                     in_dout = '0;
  logic                     in_empty = 1'b1;
  logic                     in_rd_en;
  vec_t                     out_data;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [$clog2(D+1)-1:0]   occupancy;
  logic [BW-1:0]            beat_cnt;

  int   errors = 0;
  int   checks = 0;
  int   beats  = 0;
  vec_t arr_q[$];
  vec_t exp_q[$];
  logic gap     = 1'b0;
  logic rd_prev = 1'b0;

  fifo_array_reader #(
    .FIFO_DATA_WIDTH (W),
    .ARRAY_SIZE      (N),
    .SKID_DEPTH      (D),
    .BEAT_CNT_WIDTH  (BW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk_vec(input int k);
    vec_t v;
    for (int i = 0; i < int'(N); i++) v[i] = 32'(8 * k + i);
    return v;
  endfunction

  // Negedge half of a cycle: the array presents data for the read accepted on
  // the previous edge, then updates its empty flag.
  task automatic drive_edge();
    vec_t v;
    if (rd_prev) begin
      if (arr_q.size() == 0) begin
        check("read_while_empty", 1'b1, 1'b0);
      end else begin
        v = arr_q.pop_front();
        in_dout = v;
        exp_q.push_back(v);
      end
    end
    in_empty = gap || (arr_q.size() == 0);
    #1;
  endtask

  // Sample point of a cycle, then advance to the next negedge.
  task automatic finish_cycle(output logic rd, output logic vld, output vec_t dat);
    rd  = in_rd_en;
    vld = out_valid;
    dat = out_data;
    if (!reset) begin
      check("reset_rd_en", in_rd_en, 1'b0);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_occupancy", occupancy, 0);
      check("reset_beat_cnt", beat_cnt, 0);
    end else begin
      // Scoreboard holds buffered vectors plus the one in flight.
      check("occupancy", occupancy, int'(exp_q.size()) - int'(rd_prev));
      check("credit_bound", (int'(occupancy) + int'(rd_prev) <= int'(D)), 1'b1);
      check("out_valid", out_valid, (int'(exp_q.size()) > int'(rd_prev)));
    end
    rd_prev = in_rd_en;
    @(negedge clock);
  endtask

  task automatic cycle(output logic rd, output logic vld, output vec_t dat);
    drive_edge();
    finish_cycle(rd, vld, dat);
  endtask

  // Monitor: compares every presented head against the scoreboard.
  initial begin
    int   cnt_m;
    vec_t held;
    logic held_v;
    cnt_m  = 0;
    held   = '0;
    held_v = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        exp_q.delete();
        cnt_m  = 0;
        held_v = 1'b0;
      end else begin
        check("beat_cnt", beat_cnt, cnt_m % (1 << BW));
        if (held_v) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_data", out_data, held);
        end
        held_v = 1'b0;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("beat_without_read", out_valid, 1'b0);
          end else begin
            check("out_data", out_data, exp_q[0]);
            if (out_ready) begin
              void'(exp_q.pop_front());
              cnt_m++;
              beats++;
            end else begin
              held_v = 1'b1;
              held   = out_data;
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd, vld, hit, saw_gap, seen_valid, first_seen;
    vec_t dat;
    int   n, start;
    @(negedge clock);

    // Reset held with data available and downstream ready.
    for (int k = 0; k < 8; k++) arr_q.push_back(mk_vec(k));
    out_ready = 1'b1;
    reset     = 1'b0;
    repeat (5) cycle(rd, vld, dat);

    // Stream of 8 vectors.
    start = beats;
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle(rd, vld, dat);
      check($sformatf("stream_rd_en_c%0d", c), rd, (c < 8));
      check($sformatf("stream_valid_c%0d", c), vld, (c >= 2 && c <= 9));
    end
    check("stream_beat_cnt", beat_cnt, 8);
    check("stream_beats", beats - start, 8);

    // Backpressure.
    reset = 1'b0;
    arr_q.delete();
    repeat (2) cycle(rd, vld, dat);
    for (int k = 100; k < 110; k++) arr_q.push_back(mk_vec(k));
    out_ready = 1'b0;
    start     = beats;
    reset     = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(rd, vld, dat);
      n += int'(rd);
    end
    check("bp_reads", n, 3);
    check("bp_occupancy", occupancy, 3);
    check("bp_rd_en_low", in_rd_en, 1'b0);
    check("bp_head", out_data, mk_vec(100));
    out_ready = 1'b1;
    cycle(rd, vld, dat);
    check("bp_rd_en_at_release", rd, 1'b0);
    cycle(rd, vld, dat);
    check("bp_rd_en_after_pop", rd, 1'b1);
    n = 0;
    while (beats - start < 10 && n < 40) begin
      cycle(rd, vld, dat);
      n++;
    end
    check("bp_delivered", beats - start, 10);
    check("bp_leftover", exp_q.size(), 0);
    check("bp_array_drained", arr_q.size(), 0);

    // Empty gaps: 3 cycles available, 2 cycles empty.
    reset = 1'b0;
    arr_q.delete();
    repeat (2) cycle(rd, vld, dat);
    for (int k = 200; k < 212; k++) arr_q.push_back(mk_vec(k));
    start      = beats;
    reset      = 1'b1;
    n          = 0;
    saw_gap    = 1'b0;
    seen_valid = 1'b0;
    while (beats - start < 12 && n < 80) begin
      gap = ((n % 5) >= 3);
      cycle(rd, vld, dat);
      if (vld) seen_valid = 1'b1;
      else if (seen_valid && beats - start < 12) saw_gap = 1'b1;
      n++;
    end
    gap = 1'b0;
    check("gap_delivered", beats - start, 12);
    check("gap_valid_gaps", saw_gap, 1'b1);
    check("gap_beat_cnt", beat_cnt, 12);

    // Mid-operation asynchronous reset with occupancy 2 and a read in flight.
    reset = 1'b0;
    arr_q.delete();
    repeat (2) cycle(rd, vld, dat);
    for (int k = 300; k < 310; k++) arr_q.push_back(mk_vec(k));
    start = beats;
    reset = 1'b1;
    repeat (4) cycle(rd, vld, dat);
    check("mr_pre_beats", beats - start, 2);
    out_ready = 1'b0;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 10) begin
      drive_edge();
      if (occupancy == 2 && rd_prev) hit = 1'b1;
      else begin
        finish_cycle(rd, vld, dat);
        n++;
      end
    end
    check("mr_precondition", hit, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mr_async_valid", out_valid, 1'b0);
    check("mr_async_occupancy", occupancy, 0);
    check("mr_async_beat_cnt", beat_cnt, 0);
    check("mr_async_rd_en", in_rd_en, 1'b0);
    rd_prev = 1'b0;
    @(negedge clock);
    repeat (2) cycle(rd, vld, dat);
    out_ready  = 1'b1;
    start      = beats;
    reset      = 1'b1;
    n          = 0;
    first_seen = 1'b0;
    while (beats - start < 5 && n < 40) begin
      cycle(rd, vld, dat);
      if (vld && !first_seen) begin
        first_seen = 1'b1;
        check("mr_first_beat", dat, mk_vec(305));
      end
      n++;
    end
    check("mr_delivered", beats - start, 5);
    check("mr_beat_cnt", beat_cnt, 5);

    // Counter wrap with a 4-bit beat counter.
    reset = 1'b0;
    arr_q.delete();
    repeat (2) cycle(rd, vld, dat);
    for (int k = 400; k < 417; k++) arr_q.push_back(mk_vec(k));
    start = beats;
    reset = 1'b1;
    n = 0;
    while (beats - start < 17 && n < 60) begin
      cycle(rd, vld, dat);
      if (beats - start == 15) check("wrap_cnt_15", beat_cnt, 15);
      if (beats - start == 16) check("wrap_cnt_16", beat_cnt, 0);
      n++;
    end
    check("wrap_delivered", beats - start, 17);
    check("wrap_cnt_17", beat_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
